// File: rtl/param_issue_slot.sv
// param_issue_slot: one issue-queue slot holding a uop until its sources are ready and it is granted
// Ports: clk, reset (sync, active-low); in_* load a new uop; wakeup_valid/wakeup_pdst broadcast
// ready tags; br_resolve_mask/br_mispredict_mask update or squash by branch; grant/kill/clear
// control the slot; valid/will_be_valid/request status; uop_* current contents; out_* next-cycle
// contents for compaction. Macro ISSUE_SLOT_FAST_WAKEUP_EN adds same-cycle wakeups to request.
`timescale 1ns/1ps
module param_issue_slot #(
    parameter int NUM_WAKEUP = 2,
    parameter int PREG_W = 7,
    parameter int BR_MASK_W = 12,
    parameter int PAYLOAD_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [1:0]                   in_state,
    input  logic [PREG_W-1:0]            in_pdst,
    input  logic [PREG_W-1:0]            in_prs1,
    input  logic [PREG_W-1:0]            in_prs2,
    input  logic                         in_prs1_busy,
    input  logic                         in_prs2_busy,
    input  logic [BR_MASK_W-1:0]         in_br_mask,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst,
    input  logic [BR_MASK_W-1:0]         br_resolve_mask,
    input  logic [BR_MASK_W-1:0]         br_mispredict_mask,
    input  logic                         grant,
    input  logic                         kill,
    input  logic                         clear,
    output logic                         valid,
    output logic                         will_be_valid,
    output logic                         request,
    output logic [1:0]                   uop_state,
    output logic [PREG_W-1:0]            uop_pdst,
    output logic [PREG_W-1:0]            uop_prs1,
    output logic [PREG_W-1:0]            uop_prs2,
    output logic                         uop_p1,
    output logic                         uop_p2,
    output logic [BR_MASK_W-1:0]         uop_br_mask,
    output logic [PAYLOAD_W-1:0]         uop_payload,
    output logic [1:0]                   out_state,
    output logic                         out_p1,
    output logic                         out_p2,
    output logic [BR_MASK_W-1:0]         out_br_mask
);
    typedef enum logic [1:0] {S_INV = 2'b00, S_V1 = 2'b01, S_V2 = 2'b10} state_e;
    state_e                 state_q, state_d, in_st;
    logic [PREG_W-1:0]      pdst_q, prs1_q, prs2_q;
    logic                   p1_q, p1_d, p2_q, p2_d;
    logic [BR_MASK_W-1:0]   br_mask_q, br_mask_d;
    logic [PAYLOAD_W-1:0]   payload_q;
    logic                   wk1, wk2, in_wk1, in_wk2, mis_hit, p1_rdy, p2_rdy, grant_ok;
    always_comb begin
        wk1 = 1'b0;
        wk2 = 1'b0;
        in_wk1 = 1'b0;
        in_wk2 = 1'b0;
        for (int i = 0; i < NUM_WAKEUP; i++) begin
            wk1 = wk1 | (wakeup_valid[i] && wakeup_pdst[i*PREG_W +: PREG_W] == prs1_q);
            wk2 = wk2 | (wakeup_valid[i] && wakeup_pdst[i*PREG_W +: PREG_W] == prs2_q);
            in_wk1 = in_wk1 | (wakeup_valid[i] && wakeup_pdst[i*PREG_W +: PREG_W] == in_prs1);
            in_wk2 = in_wk2 | (wakeup_valid[i] && wakeup_pdst[i*PREG_W +: PREG_W] == in_prs2);
        end
    end
`ifdef ISSUE_SLOT_FAST_WAKEUP_EN
    assign p1_rdy = p1_q | wk1;
    assign p2_rdy = p2_q | wk2;
`else
    assign p1_rdy = p1_q;
    assign p2_rdy = p2_q;
`endif
    // The reserved encoding 11 is folded to INVALID so it can never be stored.
    assign in_st = (in_state == 2'b11) ? S_INV : state_e'(in_state);
    assign valid = state_q != S_INV;
    assign mis_hit = (valid && |(br_mask_q & br_mispredict_mask)) ||
                     (in_valid && |(in_br_mask & br_mispredict_mask));
    assign request = valid & p1_rdy & p2_rdy & ~kill & ~mis_hit;
    assign grant_ok = grant & request;
    assign will_be_valid = valid & ~kill & ~mis_hit & ~(grant && state_q == S_V1) & ~clear;
    always_comb begin
        state_d = (kill || mis_hit) ? S_INV :
                  in_valid ? in_st :
                  (grant_ok && state_q == S_V1) ? S_INV :
                  (grant_ok && state_q == S_V2) ? S_V1 :
                  clear ? S_INV : state_q;
        p1_d = in_valid ? (!in_prs1_busy || in_wk1) : (p1_q || wk1);
        p2_d = in_valid ? (!in_prs2_busy || in_wk2) : (p2_q || wk2);
        br_mask_d = (in_valid ? in_br_mask : br_mask_q) & ~br_resolve_mask;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_INV;
            p1_q <= 1'b0;
            p2_q <= 1'b0;
            br_mask_q <= '0;
            payload_q <= '0;
            pdst_q <= '0;
            prs1_q <= '0;
            prs2_q <= '0;
        end else begin
            state_q <= state_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            br_mask_q <= br_mask_d;
            if (in_valid) begin
                payload_q <= in_payload;
                pdst_q <= in_pdst;
                prs1_q <= in_prs1;
                prs2_q <= in_prs2;
            end
        end
    end
    assign uop_state = state_q;
    assign uop_pdst = pdst_q;
    assign uop_prs1 = prs1_q;
    assign uop_prs2 = prs2_q;
    assign uop_p1 = p1_q;
    assign uop_p2 = p2_q;
    assign uop_br_mask = br_mask_q;
    assign uop_payload = payload_q;
    assign out_state = state_d;
    assign out_p1 = p1_d;
    assign out_p2 = p2_d;
    assign out_br_mask = br_mask_d;
endmodule

// File: tb/tb_param_issue_slot.sv
// tb_param_issue_slot: scoreboard-driven bench for param_issue_slot
`timescale 1ns/1ps
module tb_param_issue_slot;
    localparam int NW = 2;
    localparam int PW = 7;
    localparam int BW = 12;
    localparam int DW = 32;
`ifdef ISSUE_SLOT_FAST_WAKEUP_EN
    localparam logic FAST = 1'b1;
`else
    localparam logic FAST = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset, in_valid, in_prs1_busy, in_prs2_busy, grant, kill, clear;
    logic [1:0] in_state;
    logic [PW-1:0] in_pdst, in_prs1, in_prs2;
    logic [BW-1:0] in_br_mask, br_resolve_mask, br_mispredict_mask;
    logic [DW-1:0] in_payload;
    logic [NW-1:0] wakeup_valid;
    logic [NW*PW-1:0] wakeup_pdst;
    logic valid, will_be_valid, request, uop_p1, uop_p2, out_p1, out_p2;
    logic [1:0] uop_state, out_state;
    logic [PW-1:0] uop_pdst, uop_prs1, uop_prs2;
    logic [BW-1:0] uop_br_mask, out_br_mask;
    logic [DW-1:0] uop_payload;
    int checks = 0;
    int errors = 0;
    logic [50:0] sb[$];
    logic [50:0] e;
    wire [50:0] obs = {uop_payload, uop_br_mask, uop_state, valid, will_be_valid, request, uop_p1, uop_p2};

    param_issue_slot #(.NUM_WAKEUP(NW), .PREG_W(PW), .BR_MASK_W(BW), .PAYLOAD_W(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_state(in_state), .in_pdst(in_pdst),
        .in_prs1(in_prs1), .in_prs2(in_prs2), .in_prs1_busy(in_prs1_busy), .in_prs2_busy(in_prs2_busy),
        .in_br_mask(in_br_mask), .in_payload(in_payload), .wakeup_valid(wakeup_valid),
        .wakeup_pdst(wakeup_pdst), .br_resolve_mask(br_resolve_mask), .br_mispredict_mask(br_mispredict_mask),
        .grant(grant), .kill(kill), .clear(clear), .valid(valid), .will_be_valid(will_be_valid),
        .request(request), .uop_state(uop_state), .uop_pdst(uop_pdst), .uop_prs1(uop_prs1),
        .uop_prs2(uop_prs2), .uop_p1(uop_p1), .uop_p2(uop_p2), .uop_br_mask(uop_br_mask),
        .uop_payload(uop_payload), .out_state(out_state), .out_p1(out_p1), .out_p2(out_p2),
        .out_br_mask(out_br_mask)
    );

    always #5 clk = ~clk;

    function automatic logic [50:0] mk(logic [BW-1:0] bm, logic [1:0] st, logic v, logic wbv,
                                       logic rq, logic p1, logic p2, logic [DW-1:0] pl);
        return {pl, bm, st, v, wbv, rq, p1, p2};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b1; in_valid = 1'b0; in_state = 2'b00; in_pdst = '0; in_prs1 = '0; in_prs2 = '0;
        in_prs1_busy = 1'b0; in_prs2_busy = 1'b0; in_br_mask = '0; in_payload = '0;
        wakeup_valid = '0; wakeup_pdst = '0; br_resolve_mask = '0; br_mispredict_mask = '0;
        grant = 1'b0; kill = 1'b0; clear = 1'b0;
    endtask

    task automatic set_load(input logic [1:0] st, input logic [PW-1:0] rs1, input logic [PW-1:0] rs2,
                            input logic b1, input logic b2, input logic [BW-1:0] bm, input logic [DW-1:0] pl);
        in_valid = 1'b1; in_state = st; in_pdst = rs1 + 7'd1; in_prs1 = rs1; in_prs2 = rs2;
        in_prs1_busy = b1; in_prs2_busy = b2; in_br_mask = bm; in_payload = pl;
    endtask

    task automatic wake(input int port, input logic [PW-1:0] tag);
        wakeup_valid[port] = 1'b1;
        wakeup_pdst[port*PW +: PW] = tag;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            idle();
            if (k == 0) begin
                reset = 1'b0;
                set_load(2'b10, 7'd1, 7'd2, 1'b0, 1'b0, 12'hfff, 32'hdead_beef);
                grant = 1'b1;
            end
            sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL reset step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_wakeup();
        logic [DW-1:0] p = 32'ha5a5_0001;
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b01, 7'd5, 7'd6, 1'b1, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: sb.push_back(mk(0, 1, 1, 1, 0, 0, 1, p));
                2: begin wakeup_pdst[PW +: PW] = 7'd5; sb.push_back(mk(0, 1, 1, 1, 0, 0, 1, p)); end
                3: begin wake(1, 7'd5); sb.push_back(mk(0, 1, 1, 1, FAST, 0, 1, p)); end
                default: sb.push_back(mk(0, 1, 1, 1, 1, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL wakeup step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_grant();
        logic [DW-1:0] p = 32'h1234_5678;
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b10, 7'd1, 7'd2, 1'b0, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin grant = 1'b1; sb.push_back(mk(0, 2, 1, 1, 1, 1, 1, p)); end
                2: begin grant = 1'b1; sb.push_back(mk(0, 1, 1, 0, 1, 1, 1, p)); end
                default: sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL grant step %0d: got %h expected %h", k, obs, e); end
            if (k == 1) begin
                checks++;
                if (out_state !== 2'd1) begin errors++; $display("FAIL grant out_state: got %0d expected 1", out_state); end
            end
            tick();
        end
    endtask

    task automatic test_grant_ignored();
        logic [DW-1:0] p = 32'h0bad_f00d;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b10, 7'd3, 7'd4, 1'b1, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin grant = 1'b1; sb.push_back(mk(0, 2, 1, 1, 0, 0, 1, p)); end
                default: sb.push_back(mk(0, 2, 1, 1, 0, 0, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL grant_ignored step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [DW-1:0] p = 32'hcafe_0003;
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b01, 7'd1, 7'd2, 1'b0, 1'b0, 12'h004, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin br_resolve_mask = 12'h004; sb.push_back(mk(12'h004, 1, 1, 1, 1, 1, 1, p)); end
                default: sb.push_back(mk(12'h000, 1, 1, 1, 1, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL resolve step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b01, 7'd1, 7'd2, 1'b0, 1'b0, 12'h004, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin br_mispredict_mask = 12'h008; sb.push_back(mk(12'h004, 1, 1, 1, 1, 1, 1, p)); end
                2: begin br_mispredict_mask = 12'h004; sb.push_back(mk(12'h004, 1, 1, 0, 0, 1, 1, p)); end
                default: sb.push_back(mk(12'h004, 0, 0, 0, 0, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL mispredict step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_load_wakeup();
        logic [DW-1:0] p = 32'h5eed_0004;
        pulse_reset();
        for (int k = 0; k < 2; k++) begin
            idle();
            if (k == 0) begin
                set_load(2'b01, 7'd3, 7'd9, 1'b0, 1'b1, 0, p);
                wake(0, 7'd9);
                sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            end else sb.push_back(mk(0, 1, 1, 1, 1, 1, 1, p));
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL load_wakeup step %0d: got %h expected %h", k, obs, e); end
            if (k == 1) begin
                checks++;
                if ({uop_pdst, uop_prs1, uop_prs2, out_p1, out_p2, out_br_mask} !== {7'd4, 7'd3, 7'd9, 1'b1, 1'b1, 12'h000}) begin
                    errors++;
                    $display("FAIL load_wakeup tags: got %h %h %h %b %b %h expected 04 03 09 1 1 000",
                             uop_pdst, uop_prs1, uop_prs2, out_p1, out_p2, out_br_mask);
                end
            end
            tick();
        end
    endtask

    task automatic test_kill_reset();
        logic [DW-1:0] p = 32'h0000_0c55;
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b01, 7'd1, 7'd2, 1'b1, 1'b1, 0, 0); kill = 1'b1; sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
                2: begin set_load(2'b01, 7'd1, 7'd2, 1'b0, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                3: begin kill = 1'b1; sb.push_back(mk(0, 1, 1, 0, 0, 1, 1, p)); end
                default: sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL kill step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
        pulse_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b10, 7'd1, 7'd2, 1'b0, 1'b0, 12'h003, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: begin grant = 1'b1; reset = 1'b0; sb.push_back(mk(12'h003, 2, 1, 1, 1, 1, 1, p)); end
                default: sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL midreset step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    task automatic test_illegal_clear();
        logic [DW-1:0] p = 32'h7777_0006;
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            case (k)
                0: begin set_load(2'b11, 7'd1, 7'd2, 1'b0, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); end
                1: sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, p));
                2: begin set_load(2'b01, 7'd1, 7'd2, 1'b0, 1'b0, 0, p); sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, p)); end
                3: begin clear = 1'b1; sb.push_back(mk(0, 1, 1, 0, 1, 1, 1, p)); end
                default: sb.push_back(mk(0, 0, 0, 0, 0, 1, 1, p));
            endcase
            #1;
            e = sb.pop_front(); checks++;
            if (obs !== e) begin errors++; $display("FAIL illegal_clear step %0d: got %h expected %h", k, obs, e); end
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1'b0;
        tick();
        test_reset();
        test_wakeup();
        test_grant();
        test_grant_ignored();
        test_branch();
        test_load_wakeup();
        test_kill_reset();
        test_illegal_clear();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/param_issue_slot.md
PARAM_ISSUE_SLOT -- requirements
Module: param_issue_slot

Interface
REQ-001 Parameter NUM_WAKEUP, default 2: number of wakeup ports, range 1..8.
REQ-002 Parameter PREG_W, default 7: physical register tag width.
REQ-003 Parameter BR_MASK_W, default 12: branch mask width.
REQ-004 Parameter PAYLOAD_W, default 32: opaque uop payload width (instruction bits and metadata).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  load a new uop into the slot this cycle.
REQ-008 in_state  in  2  state of the incoming uop: 00 INVALID, 01 VALID_1, 10 VALID_2.
REQ-009 in_pdst / in_prs1 / in_prs2  in  PREG_W each  destination and source tags.
REQ-010 in_prs1_busy / in_prs2_busy  in  1 each  source not yet ready.
REQ-011 in_br_mask  in  BR_MASK_W  branches the uop depends on.
REQ-012 in_payload  in  PAYLOAD_W  opaque payload, stored unmodified.
REQ-013 wakeup_valid  in  NUM_WAKEUP  per-port wakeup strobe.
REQ-014 wakeup_pdst  in  NUM_WAKEUP*PREG_W  packed wakeup tags; port i occupies bits [i*PREG_W +: PREG_W].
REQ-015 br_resolve_mask / br_mispredict_mask  in  BR_MASK_W each  branches resolved / mispredicted this cycle.
REQ-016 grant  in  1  issue select granted this slot.
REQ-017 kill  in  1  flush; highest priority.
REQ-018 clear  in  1  slot contents moved elsewhere (compaction).
REQ-019 valid  out  1  state != INVALID.
REQ-020 will_be_valid  out  1  slot remains valid next cycle, ignoring in_valid.
REQ-021 request  out  1  slot is ready to issue.
REQ-022 uop_state, uop_pdst, uop_prs1, uop_prs2, uop_p1, uop_p2, uop_br_mask, uop_payload  out  as inputs  current slot contents.
REQ-023 out_state, out_p1, out_p2, out_br_mask  out  as above  next-cycle values, for compaction into a neighbouring slot.

Function
REQ-024 State SHALL be one of INVALID, VALID_1 or VALID_2; encoding 11 SHALL never be stored and SHALL load as INVALID.
REQ-025 Next-state priority: kill or mispredict-hit -> INVALID; else in_valid -> in_state; else grant in VALID_1 -> INVALID; else grant in VALID_2 -> VALID_1; else clear -> INVALID; else hold.
REQ-026 Mispredict-hit SHALL be (uop_br_mask & br_mispredict_mask) != 0 while valid, or (in_br_mask & br_mispredict_mask) != 0 when loading.
REQ-027 Stored br_mask SHALL be the selected mask (incoming or held) AND NOT br_resolve_mask, every cycle.
REQ-028 p1 SHALL load as !in_prs1_busy OR (a wakeup_valid[i] with wakeup_pdst[i] == in_prs1); p2 likewise with in_prs2.
REQ-029 A held p1 (p2) SHALL set when any valid wakeup port matches uop_prs1 (uop_prs2), and SHALL never clear until the next load.
REQ-030 request SHALL be valid AND p1 AND p2 AND NOT kill AND NOT mispredict-hit.
REQ-031 will_be_valid SHALL be valid AND NOT kill AND NOT mispredict-hit AND NOT (grant AND state == VALID_1) AND NOT clear.
REQ-032 grant while request is low SHALL be ignored.
REQ-033 Payload and tags SHALL update only on in_valid.

Reset
REQ-034 While reset is low at a clock edge: state INVALID; p1, p2, br_mask and payload zero; valid, will_be_valid and request SHALL be 0 from the following cycle.
REQ-035 Reset SHALL override in_valid, kill and grant in the same cycle.

Configuration
REQ-036 Macro ISSUE_SLOT_FAST_WAKEUP_EN defined: request SHALL also include same-cycle wakeup matches (zero-cycle wakeup); a wakeup at cycle t SHALL give request in cycle t. Undefined: request SHALL use registered p1 and p2 only, so a wakeup at cycle t SHALL give request in cycle t+1.

Verification
REQ-037 Load VALID_1, prs1=5 busy, prs2 ready; wakeup port 1 pdst=5 at cycle 3 -> request high at cycle 4 (cycle 3 with the macro defined).
REQ-038 Load VALID_2, both ready; grant -> state VALID_1 next cycle; second grant -> INVALID, will_be_valid 0 during the second grant.
REQ-039 Held br_mask=0x004; br_resolve_mask=0x004 -> br_mask 0x000, slot stays valid; separate run with br_mispredict_mask=0x004 -> INVALID next cycle and request 0 in the same cycle.
REQ-040 in_valid together with a matching wakeup for busy in_prs2=9 -> p2 loaded as 1.
REQ-041 kill together with in_valid -> INVALID; reset low mid-operation with grant high -> all outputs 0 next cycle.
